bit_serializer: RTL
===================

# bit_serializer

Parallel-to-serial front end for the serial pattern-detector stage. Accepts WIDTH-bit words over a valid/ready handshake, buffers them in a small FIFO, and emits one bit per clock on a single-bit stream that drives the detector's serial input directly. Consecutive words leave the block gap-free, so the detector sees a continuous bit stream while the FIFO is non-empty.

## Interface
- WIDTH, 8, data bits per word (≥2)
- DEPTH, 2, FIFO entries (power of two, ≥2)
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to serialize
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- out_bit  output  1  current serial bit (to detector input)
- out_valid  output  1  out_bit carries a real bit
- out_last  output  1  out_bit is the final bit of its word
- busy  output  1  shifter loaded or FIFO non-empty

One clock; reset synchronous and active-high.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes in_data to FIFO tail.
- in_ready = !fifo_full (registered state only). No push when full, even if a pop occurs the same edge.
- Shifter: shift register plus bit counter. Idle when counter = 0.
- Load: at an edge where the FIFO is non-empty and (shifter idle or current bit is last), the head word is popped into the shifter and the counter is set to the word length.
- Word length = WIDTH, or WIDTH+1 with parity (see Configuration).
- Shift: at each edge where shifter is active and no load occurs, advance one bit and decrement counter.
- out_bit = current head bit of shifter per MSB_FIRST; 0 when idle.
- out_valid = shifter active. out_last = counter == 1.
- No downstream backpressure: the consumer takes one bit every cycle out_valid is high.
- busy = out_valid || !fifo_empty.
- FIFO pointers wrap modulo DEPTH; occupancy counter is 0..DEPTH.
- Reset mid-word: the word in flight and all FIFO contents are discarded with no partial output.

## Timing
- Reset values: in_ready 0 while reset is high, 1 in the first cycle after. out_bit 0, out_valid 0, out_last 0, busy 0. FIFO empty, counter 0.
- Latency, idle block: word accepted at edge E0 enters the FIFO. Load at E1. First bit is valid in the cycle after E1.
- Word occupies exactly WIDTH (or WIDTH+1) consecutive out_valid cycles.
- Back-to-back: next word's first bit follows the previous word's out_last cycle with zero gap.
- Simultaneous push and pop, not full: both occur and occupancy is unchanged.
- Push into an empty FIFO while the shifter is on its last bit: load occurs the next edge. This gives a one-cycle gap, because there is no bypass.

## Configuration
- SERIALIZER_PARITY_EN defined: after the WIDTH data bits, one extra bit is emitted, equal to the XOR of all data bits (even parity). out_last marks the parity bit. Word period is WIDTH+1.
- Not defined: no parity bit, word period is WIDTH, and out_last marks the final data bit.

## Test plan
- WIDTH=8, MSB_FIRST=1, push 8'hA5 into an idle block -> out_bit 1,0,1,0,0,1,0,1 on 8 consecutive out_valid cycles, first valid 2 edges after acceptance. out_last only on the 8th bit. busy drops the cycle after.
- Push 8'h0B then 8'hD0 on consecutive cycles -> 16 contiguous out_valid cycles, bit stream 00001011_11010000, out_last on bits 8 and 16.
- DEPTH=2, in_valid held high with 4 words from idle -> words 1–3 accepted on consecutive edges, in_ready low after the 3rd. 4th word accepted on the edge after word 2 loads. All 32 bits emitted in order with no gaps.
- MSB_FIRST=0, push 8'h01 -> bits 1,0,0,0,0,0,0,0.
- Assert reset for 1 cycle during bit 4 of 8'hFF, with one word queued -> out_valid 0 the next cycle, busy 0, queued word never emitted, in_ready 1 after reset.
- SERIALIZER_PARITY_EN, push 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1, with out_last on the 9th bit (parity 1). Push 8'h03 -> 9th bit 0.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: FIFO-buffered word-to-bit serializer feeding the pattern detector.
// Ports: clock, reset (sync, active-high), in_data/in_valid/in_ready word input,
// out_bit/out_valid/out_last serial output, busy. Optional: SERIALIZER_PARITY_EN.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] LEN = CW'(SW);
  localparam logic [AW:0] FULLN = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [SW-1:0]    shreg;
  logic [SW-1:0]    shifted;
  logic [SW-1:0]    load_val;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             active;

  assign full   = (count == FULLN);
  assign empty  = (count == '0);
  assign active = (cnt != '0);
  assign head   = mem[rptr];

  // Ready depends on stored occupancy only; a same-edge pop never frees a slot.
  assign in_ready = !reset && !full;
  assign push     = in_valid && in_ready;
  // Reload on the last bit keeps consecutive words gap-free.
  assign pop      = !empty && (cnt <= 1);

  always_comb begin
    load_val = '0;
    shifted  = '0;
    if (MSB_FIRST != 0) begin
`ifdef SERIALIZER_PARITY_EN
      load_val = {head, ^head};
`else
      load_val = head;
`endif
      shifted  = shreg << 1;
    end else begin
`ifdef SERIALIZER_PARITY_EN
      load_val = {^head, head};
`else
      load_val = head;
`endif
      shifted  = shreg >> 1;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
      if (pop) begin
        shreg <= load_val;
        cnt   <= LEN;
      end else if (active) begin
        shreg <= shifted;
        cnt   <= cnt - 1'b1;
      end
    end
  end

  assign out_valid = active;
  assign out_last  = (cnt == 1);
  assign out_bit   = active &&
                     ((MSB_FIRST != 0) ? shreg[SW-1] : shreg[0]);
  assign busy      = active || !empty;

endmodule
